// File: rtl/qam_pkg.sv
// -----------------------------------------------------------------------------
// qam_pkg
// Shared types and constants for the QAM-16 transmit output stage.
//   QAM_DATA_W : default I/Q sample width
//   iq_state_t : output sequencer states (IDLE, SEND_I, SEND_Q)
//   iq_pair_t  : one modulated {i, q} sample pair at the default width
// -----------------------------------------------------------------------------
package qam_pkg;

    localparam int QAM_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEND_I = 2'd1,
        SEND_Q = 2'd2
    } iq_state_t;

    typedef struct packed {
        logic signed [QAM_DATA_W-1:0] i;
        logic signed [QAM_DATA_W-1:0] q;
    } iq_pair_t;

endpackage

// File: rtl/qam_pair_fifo.sv
// -----------------------------------------------------------------------------
// qam_pair_fifo
// Circular buffer of packed {I,Q} sample pairs. Push is ignored when full and
// pop is ignored when empty; the caller decides what a refused push means.
// Ports:
//   clk, reset        : rising-edge clock, synchronous active-high reset
//   push, push_data   : write one pair (WIDTH bits, {i, q})
//   pop, pop_data     : pop_data always shows the head; pop advances it
//   full, empty       : derived from the registered level
//   level             : number of stored pairs (0..DEPTH)
// -----------------------------------------------------------------------------
module qam_pair_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push,
    input  logic [WIDTH-1:0]             push_data,
    input  logic                         pop,
    output logic [WIDTH-1:0]             pop_data,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (level == LVL_W'(DEPTH));
    assign empty    = (level == '0);
    assign do_push  = push & ~full;
    assign do_pop   = pop & ~empty;
    assign pop_data = mem[rd_ptr];

    // Storage carries no reset; only pointers and level define validity.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/qam_iq_interleaver.sv
// -----------------------------------------------------------------------------
// qam_iq_interleaver
// Output stage of the QAM-16 transmit chain. Captures each modulated I/Q pair
// on in_valid into a small FIFO and replays the pairs as an I-then-Q word
// stream on a valid/ready interface. The modulator cannot be stalled, so a
// pair arriving while the FIFO is full is dropped and flagged.
// Ports:
//   clk, reset          : rising-edge clock, synchronous active-high reset
//   in_valid, in_i, in_q: modulator sample pair (no backpressure)
//   out_valid, out_ready: output handshake
//   out_data, out_is_q  : current word, 0 = I word, 1 = Q word
//   level               : pairs stored in the FIFO (excludes pair being sent)
//   overflow            : sticky drop flag, cleared only by reset
// Optional (macro QAM_IQ_INTERLEAVER_STATS_EN):
//   drop_count          : dropped pairs, saturating at 16'hFFFF
//   pair_count          : completed Q transfers, wrapping
// -----------------------------------------------------------------------------
module qam_iq_interleaver
    import qam_pkg::*;
#(
    parameter int DATA_W = QAM_DATA_W,
    parameter int DEPTH  = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_valid,
    input  logic signed [DATA_W-1:0]     in_i,
    input  logic signed [DATA_W-1:0]     in_q,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic signed [DATA_W-1:0]     out_data,
    output logic                         out_is_q,
    output logic [$clog2(DEPTH+1)-1:0]   level,
    output logic                         overflow
`ifdef QAM_IQ_INTERLEAVER_STATS_EN
    ,
    output logic [15:0]                  drop_count,
    output logic [15:0]                  pair_count
`endif
);

    iq_state_t                state;
    logic                     push;
    logic                     drop;
    logic                     pop;
    logic                     full;
    logic                     empty;
    logic [2*DATA_W-1:0]      push_data;
    logic [2*DATA_W-1:0]      pop_data;
    logic signed [DATA_W-1:0] head_i;
    logic signed [DATA_W-1:0] head_q;
    logic signed [DATA_W-1:0] hold_q_p1;

    // Full is judged on the registered level, so a pop in the same cycle
    // never makes room for this cycle's push.
    assign push      = in_valid & ~full;
    assign drop      = in_valid & full;
    assign push_data = {in_i, in_q};
    assign head_i    = pop_data[2*DATA_W-1:DATA_W];
    assign head_q    = pop_data[DATA_W-1:0];

    // Pop from IDLE, or back-to-back after the Q word is accepted.
    assign pop = ~empty & ((state == IDLE) | ((state == SEND_Q) & out_ready));

    qam_pair_fifo #(
        .WIDTH (2*DATA_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .pop_data  (pop_data),
        .full      (full),
        .empty     (empty),
        .level     (level)
    );

    // ---- Output stage: hold registers and I/Q sequencer ----
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_is_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (!empty) begin
                        out_data  <= head_i;
                        hold_q_p1 <= head_q;
                        out_is_q  <= 1'b0;
                        out_valid <= 1'b1;
                        state     <= SEND_I;
                    end else begin
                        out_valid <= 1'b0;
                    end
                end
                SEND_I: begin
                    if (out_ready) begin
                        out_data <= hold_q_p1;
                        out_is_q <= 1'b1;
                        state    <= SEND_Q;
                    end
                end
                SEND_Q: begin
                    if (out_ready) begin
                        if (!empty) begin
                            out_data  <= head_i;
                            hold_q_p1 <= head_q;
                            out_is_q  <= 1'b0;
                            state     <= SEND_I;
                        end else begin
                            out_valid <= 1'b0;
                            state     <= IDLE;
                        end
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end
    end

`ifdef QAM_IQ_INTERLEAVER_STATS_EN
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            drop_count <= '0;
            pair_count <= '0;
        end else begin
            if (drop) begin
                drop_count <= sat_inc16(drop_count);
            end
            if ((state == SEND_Q) && out_ready) begin
                pair_count <= pair_count + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_qam_iq_interleaver.sv
// -----------------------------------------------------------------------------
// tb_qam_iq_interleaver
// Directed self-checking bench for qam_iq_interleaver (DATA_W=32, DEPTH=8).
// Optional statistics ports are checked when QAM_IQ_INTERLEAVER_STATS_EN is set.
// -----------------------------------------------------------------------------
module tb_qam_iq_interleaver;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic [31:0] in_i;
    logic [31:0] in_q;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_is_q;
    logic [3:0]  level;
    logic        overflow;
`ifdef QAM_IQ_INTERLEAVER_STATS_EN
    logic [15:0] drop_count;
    logic [15:0] pair_count;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    qam_iq_interleaver #(
        .DATA_W (32),
        .DEPTH  (8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_i       (in_i),
        .in_q       (in_q),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_is_q   (out_is_q),
        .level      (level),
        .overflow   (overflow)
`ifdef QAM_IQ_INTERLEAVER_STATS_EN
        ,
        .drop_count (drop_count),
        .pair_count (pair_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle just past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b0; in_i = '0; in_q = '0; out_ready = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
        n_cmp++; if (out_data !== 32'h0) begin n_fail++; $display("FAIL reset_out_data got %h want 0", out_data); end
        n_cmp++; if (out_is_q !== 1'b0) begin n_fail++; $display("FAIL reset_out_is_q got %0b want 0", out_is_q); end
        n_cmp++; if (level !== 4'd0) begin n_fail++; $display("FAIL reset_level got %0d want 0", level); end
        n_cmp++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow got %0b want 0", overflow); end
`ifdef QAM_IQ_INTERLEAVER_STATS_EN
        n_cmp++; if (drop_count !== 16'd0) begin n_fail++; $display("FAIL reset_drop_count got %0d want 0", drop_count); end
        n_cmp++; if (pair_count !== 16'd0) begin n_fail++; $display("FAIL reset_pair_count got %0d want 0", pair_count); end
`endif
    endtask

    task automatic test_single_pair();
        out_ready = 1'b1;
        in_valid = 1'b1; in_i = 32'h0000_0005; in_q = 32'hFFFF_FFFB;
        tick();
        in_valid = 1'b0;
        n_cmp++; if (level !== 4'd1) begin n_fail++; $display("FAIL single_level1 got %0d want 1", level); end
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_early_valid got %0b want 0", out_valid); end
        tick();
        n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid_i got %0b want 1", out_valid); end
        n_cmp++; if (out_data !== 32'h0000_0005) begin n_fail++; $display("FAIL single_data_i got %h want 00000005", out_data); end
        n_cmp++; if (out_is_q !== 1'b0) begin n_fail++; $display("FAIL single_is_q_i got %0b want 0", out_is_q); end
        n_cmp++; if (level !== 4'd0) begin n_fail++; $display("FAIL single_level0 got %0d want 0", level); end
        tick();
        n_cmp++; if (out_data !== 32'hFFFF_FFFB) begin n_fail++; $display("FAIL single_data_q got %h want fffffffb", out_data); end
        n_cmp++; if (out_is_q !== 1'b1) begin n_fail++; $display("FAIL single_is_q_q got %0b want 1", out_is_q); end
        n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid_q got %0b want 1", out_valid); end
        tick();
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_valid_end got %0b want 0", out_valid); end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        in_valid = 1'b1; in_i = 32'h0000_0011; in_q = 32'h0000_0022;
        tick();
        in_valid = 1'b0;
        tick();
        for (int c = 0; c < 5; c++) begin
            tick();
            n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid c=%0d got %0b want 1", c, out_valid); end
            n_cmp++; if (out_data !== 32'h0000_0011) begin n_fail++; $display("FAIL bp_data c=%0d got %h want 00000011", c, out_data); end
            n_cmp++; if (out_is_q !== 1'b0) begin n_fail++; $display("FAIL bp_is_q c=%0d got %0b want 0", c, out_is_q); end
        end
        out_ready = 1'b1;
        tick();
        n_cmp++; if (out_data !== 32'h0000_0022) begin n_fail++; $display("FAIL bp_release_q got %h want 00000022", out_data); end
        n_cmp++; if (out_is_q !== 1'b1) begin n_fail++; $display("FAIL bp_release_is_q got %0b want 1", out_is_q); end
        tick();
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_done_valid got %0b want 0", out_valid); end
    endtask

    // Pair p carries I = p, Q = -p; also covers the full+simultaneous-pop case.
    task automatic test_overflow();
        logic [31:0] exp_w;
        int          p;
        out_ready = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            in_valid = 1'b1; in_i = 32'(k); in_q = 32'(-k);
            tick();
            if (k == 9) begin
                n_cmp++; if (level !== 4'd8) begin n_fail++; $display("FAIL ovf_level_at9 got %0d want 8", level); end
                n_cmp++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_early got %0b want 0", overflow); end
            end
        end
        in_valid = 1'b0;
        n_cmp++; if (level !== 4'd8) begin n_fail++; $display("FAIL ovf_level got %0d want 8", level); end
        n_cmp++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag got %0b want 1", overflow); end
        n_cmp++; if (out_data !== 32'd1) begin n_fail++; $display("FAIL ovf_hold_i got %h want 00000001", out_data); end
`ifdef QAM_IQ_INTERLEAVER_STATS_EN
        n_cmp++; if (drop_count !== 16'd3) begin n_fail++; $display("FAIL ovf_drop_count got %0d want 3", drop_count); end
`endif
        out_ready = 1'b1;
        tick();
        n_cmp++; if (out_data !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL ovf_q1 got %h want ffffffff", out_data); end
        n_cmp++; if (level !== 4'd8) begin n_fail++; $display("FAIL full_pop_pre_level got %0d want 8", level); end
        in_valid = 1'b1; in_i = 32'd99; in_q = 32'd199;
        tick();
        in_valid = 1'b0;
        n_cmp++; if (level !== 4'd7) begin n_fail++; $display("FAIL full_pop_level got %0d want 7", level); end
        n_cmp++; if (out_data !== 32'd2 || out_is_q !== 1'b0) begin n_fail++; $display("FAIL full_pop_i2 got %h/%0b want 00000002/0", out_data, out_is_q); end
`ifdef QAM_IQ_INTERLEAVER_STATS_EN
        n_cmp++; if (drop_count !== 16'd4) begin n_fail++; $display("FAIL full_pop_drop_count got %0d want 4", drop_count); end
`endif
        for (int j = 3; j < 18; j++) begin
            tick();
            p = j / 2 + 1;
            exp_w = (j % 2 == 1) ? 32'(-p) : 32'(p);
            n_cmp++; if (out_valid !== 1'b1 || out_data !== exp_w || out_is_q !== 1'(j % 2))
                begin n_fail++; $display("FAIL drain_word%0d got %0b/%h/%0b want 1/%h/%0b", j, out_valid, out_data, out_is_q, exp_w, j % 2); end
        end
        tick();
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL drain_end_valid got %0b want 0", out_valid); end
        n_cmp++; if (level !== 4'd0) begin n_fail++; $display("FAIL drain_end_level got %0d want 0", level); end
    endtask

    task automatic test_wrap();
        int          widx;
        int          p;
        logic [31:0] exp_w;
        apply_reset();
        out_ready = 1'b1;
        widx = 0;
        for (int cyc = 0; cyc < 90; cyc++) begin
            in_valid = (cyc < 80) && (cyc % 2 == 0);
            in_i = 32'h1000_0000 + 32'(cyc / 2);
            in_q = 32'hF000_0000 + 32'(cyc / 2);
            tick();
            if (out_valid === 1'b1) begin
                p = widx / 2;
                exp_w = (widx % 2 == 1) ? 32'hF000_0000 + 32'(p) : 32'h1000_0000 + 32'(p);
                n_cmp++; if (widx >= 80 || out_data !== exp_w || out_is_q !== 1'(widx % 2))
                    begin n_fail++; $display("FAIL wrap_word%0d got %h/%0b want %h/%0b", widx, out_data, out_is_q, exp_w, widx % 2); end
                widx++;
            end
        end
        in_valid = 1'b0;
        n_cmp++; if (widx != 80) begin n_fail++; $display("FAIL wrap_count got %0d want 80", widx); end
        n_cmp++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL wrap_overflow got %0b want 0", overflow); end
`ifdef QAM_IQ_INTERLEAVER_STATS_EN
        n_cmp++; if (pair_count !== 16'd40) begin n_fail++; $display("FAIL wrap_pair_count got %0d want 40", pair_count); end
`endif
    endtask

    task automatic test_reset_mid_stream();
        apply_reset();
        out_ready = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            in_valid = 1'b1; in_i = 32'(k + 50); in_q = 32'(k + 60);
            tick();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        n_cmp++; if (level !== 4'd4 || out_is_q !== 1'b1) begin n_fail++; $display("FAIL mid_setup got level %0d is_q %0b want 4/1", level, out_is_q); end
        reset = 1'b1; in_valid = 1'b1; in_i = 32'h77; in_q = 32'h78; out_ready = 1'b0;
        tick();
        reset = 1'b0; in_valid = 1'b0;
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rst_valid got %0b want 0", out_valid); end
        n_cmp++; if (out_data !== 32'h0 || out_is_q !== 1'b0) begin n_fail++; $display("FAIL mid_rst_data got %h/%0b want 0/0", out_data, out_is_q); end
        n_cmp++; if (level !== 4'd0 || overflow !== 1'b0) begin n_fail++; $display("FAIL mid_rst_level got %0d/%0b want 0/0", level, overflow); end
        tick();
        n_cmp++; if (level !== 4'd0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rst_ignored_in got level %0d valid %0b want 0/0", level, out_valid); end
        in_valid = 1'b1; in_i = 32'hAB; in_q = 32'hCD;
        tick();
        in_valid = 1'b0;
        n_cmp++; if (out_valid !== 1'b0 || level !== 4'd1) begin n_fail++; $display("FAIL mid_post_c1 got valid %0b level %0d want 0/1", out_valid, level); end
        tick();
        n_cmp++; if (out_valid !== 1'b1 || out_data !== 32'hAB || out_is_q !== 1'b0) begin n_fail++; $display("FAIL mid_post_i got %0b/%h/%0b want 1/000000ab/0", out_valid, out_data, out_is_q); end
        out_ready = 1'b1;
        tick();
        n_cmp++; if (out_data !== 32'hCD || out_is_q !== 1'b1) begin n_fail++; $display("FAIL mid_post_q got %h/%0b want 000000cd/1", out_data, out_is_q); end
        tick();
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_post_end got %0b want 0", out_valid); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_pair();
        test_backpressure();
        test_overflow();
        test_wrap();
        test_reset_mid_stream();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
